bit_timer_ctrl: RTL and testbench

Frame-timing controller that sequences two `flex_counter` instances to produce per-bit sample strobes for a serial receiver/transmitter. On a start pulse it latches the frame configuration and runs a clock-divider counter and a bit counter. It issues one `shift_strobe` per bit period and a `packet_done` pulse after the last bit. It sits between the serial FSM (RCU) and the shift register, replacing ad-hoc counter control in each protocol block.

---
 rtl/bit_timer_pkg.sv | 14 +
 rtl/flex_counter.sv | 47 ++++
 rtl/bit_timer_ctrl.sv | 135 +++++++++++++
 tb/tb_bit_timer_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bit_timer_pkg.sv
// Shared types and constants for the bit timing controller.
package bit_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } bt_state_t;

  // Shortest bit period the divider can produce with a distinct strobe per bit.
  localparam int unsigned BT_MIN_CLKS_PER_BIT = 2;

endpackage

// File: rtl/flex_counter.sv
// Loadable-rollover up counter: counts 1..rollover_val, then wraps to 1.
// Synchronous clear has priority over count_enable.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  // Next count: clear wins, otherwise increment and wrap to 1 at rollover.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag tracks the current count so it lines up with the cycle it describes.
  always_comb begin
    count_out     = count_q;
    rollover_flag = (count_q == rollover_val);
  end

endmodule

// File: rtl/bit_timer_ctrl.sv
// Frame timing controller: a clock divider and a bit counter sequenced by a
// small FSM to give one shift strobe per bit and a done pulse per frame.
module bit_timer_ctrl
  import bit_timer_pkg::*;
#(
  parameter int unsigned CLK_CNT_BITS = 4,
  parameter int unsigned BIT_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CLK_CNT_BITS-1:0] clks_per_bit,
  input  logic [BIT_CNT_BITS-1:0] num_bits,
  output logic                    busy,
  output logic                    shift_strobe,
  output logic [BIT_CNT_BITS-1:0] bit_index,
  output logic                    packet_done,
  output logic                    cfg_err
);

  bt_state_t state_q;
  bt_state_t state_d;

  logic [CLK_CNT_BITS-1:0] p_q;
  logic [BIT_CNT_BITS-1:0] n_q;
  logic                    cfg_err_q;

  logic                    cfg_legal;
  logic                    in_run;
  logic                    cnt_clear;
  logic                    strobe;
  logic                    last_bit;
  logic [CLK_CNT_BITS-1:0] clk_cnt;
  logic                    clk_rollover;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  logic                    bit_rollover;
  logic                    unused_cnt;

  assign cfg_legal = (clks_per_bit >= CLK_CNT_BITS'(BT_MIN_CLKS_PER_BIT)) &&
                     (num_bits != '0);
  assign in_run    = (state_q == RUN);
  // Clearing on abort leaves both counters at 0 when the FSM lands in IDLE.
  assign cnt_clear = !in_run || abort;
  assign strobe    = in_run && clk_rollover && !abort;
  assign last_bit  = (bit_cnt == (n_q - BIT_CNT_BITS'(1)));

  // The divider count and bit-counter flag are not needed by the control path.
  assign unused_cnt = ^{clk_cnt, bit_rollover};

  flex_counter #(
    .NUM_CNT_BITS (CLK_CNT_BITS)
  ) u_clk_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (in_run),
    .rollover_val  (p_q),
    .count_out     (clk_cnt),
    .rollover_flag (clk_rollover)
  );

  flex_counter #(
    .NUM_CNT_BITS (BIT_CNT_BITS)
  ) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (cnt_clear),
    .count_enable  (strobe),
    .rollover_val  (n_q),
    .count_out     (bit_cnt),
    .rollover_flag (bit_rollover)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes precedence over a same-cycle final strobe.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = cfg_legal ? RUN : ERR;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (strobe && last_bit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration is captured once per accepted start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      p_q <= '0;
      n_q <= '0;
    end else if ((state_q == IDLE) && start && cfg_legal) begin
      p_q <= clks_per_bit;
      n_q <= num_bits;
    end
  end

  // Error pulse trails the ERR state by one cycle so it appears in cycle 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == ERR);
    end
  end

  // Output decode.
  always_comb begin
    busy         = in_run;
    shift_strobe = strobe;
    bit_index    = bit_cnt;
    packet_done  = (state_q == DONE);
    cfg_err      = cfg_err_q;
  end

endmodule

// File: tb/tb_bit_timer_ctrl.sv
// Self-checking bench for bit_timer_ctrl: table of frames, expected outputs
// derived from the frame timing formulas and queued per cycle.
module tb_bit_timer_ctrl;

  localparam int CW = 4;
  localparam int BW = 4;

  logic          tb_clk;
  logic          n_rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] clks_per_bit;
  logic [BW-1:0] num_bits;
  logic          busy;
  logic          shift_strobe;
  logic [BW-1:0] bit_index;
  logic          packet_done;
  logic          cfg_err;

  int errors = 0;
  int checks = 0;

  bit_timer_ctrl #(
    .CLK_CNT_BITS (CW),
    .BIT_CNT_BITS (BW)
  ) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .clks_per_bit (clks_per_bit),
    .num_bits     (num_bits),
    .busy         (busy),
    .shift_strobe (shift_strobe),
    .bit_index    (bit_index),
    .packet_done  (packet_done),
    .cfg_err      (cfg_err)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // One frame: inputs, mid-frame perturbations and expected pulse totals.
  typedef struct {
    int p;
    int n;
    int abort_at;  // cycle abort is held high, 0 = none
    int chg;       // change clks_per_bit/num_bits in cycle 1
    int chg_p;
    int chg_n;
    int sid;       // pulse start during the DONE cycle
    int gap;       // idle cycles after the frame
    int exp_strobes;
    int exp_done;
    int exp_err;
  } vec_t;

  typedef struct {
    int busy;
    int strobe;
    int idx;
    int done;
    int err;
    int vi;
    int ci;
  } exp_t;

  localparam int NV = 9;
  vec_t vecs[NV];
  exp_t sb_q[$];

  int obs_strobes;
  int obs_done;
  int obs_err;

  task automatic check(input string name, input int vi, input int ci,
                       input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s v%0d c%0d got %0d exp %0d", name, vi, ci, got, exp);
    end
  endtask

  function automatic int is_legal(input vec_t v);
    return (v.p >= 2 && v.n >= 1) ? 1 : 0;
  endfunction

  // Cycle index at which the controller is back in IDLE.
  function automatic int frame_end(input vec_t v);
    if (is_legal(v) == 0) return 2;
    if (v.abort_at != 0) return v.abort_at + 1;
    return v.n * v.p + 2;
  endfunction

  // Expected outputs in cycle c, where edge 0 samples start.
  function automatic exp_t exp_at(input vec_t v, input int vi, input int c);
    exp_t e;
    int   last;
    e = '{busy: 0, strobe: 0, idx: 0, done: 0, err: 0, vi: vi, ci: c};
    if (is_legal(v) == 0) begin
      e.err = (c == 1) ? 1 : 0;
      return e;
    end
    last = (v.abort_at != 0) ? v.abort_at : v.n * v.p;
    e.busy = (c <= last) ? 1 : 0;
    if (c > 0 && (c % v.p) == 0 && (c / v.p) <= v.n &&
        (v.abort_at == 0 || c < v.abort_at))
      e.strobe = 1;
    if (c <= last) e.idx = (c == 0) ? 0 : (c - 1) / v.p;
    if (v.abort_at == 0 && c == v.n * v.p + 1) begin
      e.done = 1;
      e.idx  = v.n;
    end
    return e;
  endfunction

  function automatic exp_t zero_exp(input int vi, input int c);
    exp_t e;
    e = '{busy: 0, strobe: 0, idx: 0, done: 0, err: 0, vi: vi, ci: c};
    return e;
  endfunction

  // Scoreboard consumer: compares every queued cycle on the falling edge.
  always @(negedge tb_clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("busy", e.vi, e.ci, int'(busy), e.busy);
      check("strobe", e.vi, e.ci, int'(shift_strobe), e.strobe);
      check("bit_index", e.vi, e.ci, int'(bit_index), e.idx);
      check("packet_done", e.vi, e.ci, int'(packet_done), e.done);
      check("cfg_err", e.vi, e.ci, int'(cfg_err), e.err);
      obs_strobes += int'(shift_strobe);
      obs_done    += int'(packet_done);
      obs_err     += int'(cfg_err);
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, -1, 0, int'(busy), 0);
    check({name, "_strobe"}, -1, 0, int'(shift_strobe), 0);
    check({name, "_idx"}, -1, 0, int'(bit_index), 0);
    check({name, "_done"}, -1, 0, int'(packet_done), 0);
    check({name, "_err"}, -1, 0, int'(cfg_err), 0);
  endtask

  initial begin
    vecs[0] = '{4, 3, 0, 0, 0, 0, 0, 1, 3, 1, 0};   // normal frame
    vecs[1] = '{2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};   // minimum frame
    vecs[2] = '{2, 1, 0, 0, 0, 0, 0, 2, 1, 1, 0};   // back-to-back repeat
    vecs[3] = '{5, 4, 10, 0, 0, 0, 0, 1, 1, 0, 0};  // abort on 2nd strobe
    vecs[4] = '{1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1};   // period too short
    vecs[5] = '{3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};   // zero bits
    vecs[6] = '{3, 2, 0, 1, 7, 5, 1, 2, 2, 1, 0};   // config change + start in DONE
    vecs[7] = '{15, 15, 0, 0, 0, 0, 0, 1, 15, 1, 0};// largest frame
    vecs[8] = '{3, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0};   // abort beats final strobe

    n_rst        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    clks_per_bit = '0;
    num_bits     = '0;
    obs_strobes  = 0;
    obs_done     = 0;
    obs_err      = 0;

    repeat (3) @(negedge tb_clk);
    check_all_zero("reset");
    n_rst = 1'b1;

    // Start a frame, then pull reset in the middle of RUN.
    @(posedge tb_clk); #1;
    start        = 1'b1;
    clks_per_bit = CW'(4);
    num_bits     = BW'(3);
    @(posedge tb_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge tb_clk);
    @(negedge tb_clk);
    check("midrun_busy", -1, 5, int'(busy), 1);
    check("midrun_idx", -1, 5, int'(bit_index), 1);
    @(posedge tb_clk); #1;
    n_rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge tb_clk);
    check_all_zero("rst_hold");
    n_rst = 1'b1;

    // Table of frames; the first one also shows recovery after reset.
    for (int vi = 0; vi < NV; vi++) begin
      int len;
      len = frame_end(vecs[vi]) + vecs[vi].gap;
      @(posedge tb_clk); #1;
      start        = 1'b1;
      abort        = 1'b0;
      clks_per_bit = CW'(vecs[vi].p);
      num_bits     = BW'(vecs[vi].n);
      obs_strobes  = 0;
      obs_done     = 0;
      obs_err      = 0;
      sb_q.push_back(zero_exp(vi, -1));
      for (int c = 0; c < len; c++) begin
        @(posedge tb_clk); #1;
        start = (vecs[vi].sid != 0 && c == vecs[vi].n * vecs[vi].p + 1);
        abort = (vecs[vi].abort_at != 0 && c == vecs[vi].abort_at);
        if (vecs[vi].chg != 0 && c == 1) begin
          clks_per_bit = CW'(vecs[vi].chg_p);
          num_bits     = BW'(vecs[vi].chg_n);
        end
        sb_q.push_back(exp_at(vecs[vi], vi, c));
      end
      @(negedge tb_clk); #1;
      check("strobe_count", vi, len, obs_strobes, vecs[vi].exp_strobes);
      check("done_count", vi, len, obs_done, vecs[vi].exp_done);
      check("err_count", vi, len, obs_err, vecs[vi].exp_err);
    end

    @(posedge tb_clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge tb_clk); #1;
    check("sb_drained", -1, 0, sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
